// File: rtl/seq_muldiv_alu.sv
// seq_muldiv_alu: multi-cycle signed multiply / divide / remainder, one bit per clock.
// Latency: l+1 cycles from accepted Start to Done; 1 cycle for div/rem by zero and unsupported ops.
// Backpressure: Start is only sampled in IDLE; requests while Busy or in the Done cycle are dropped.
//
// Ports:
//   Clock, Reset (async, active-high)
//   Start, Operation (0 = div, 1 = mul, 2 = rem), A, B, FlagsIn  : request side
//   Busy, Done, R, FlagsOut                                     : status / held result
// Flag bits: 0 = division has remainder, 1 = division by zero, 2 = multiplication overflow,
//            [l-1:3] pass through from the latched FlagsIn.
// Optional macro SEQ_MULDIV_EARLY_OUT_EN: multiply stops as soon as the remaining
// multiplier bits are zero (latency = msb index of |B| + 2; |B| = 0 finishes in 1 cycle).

module seq_muldiv_alu #(
  parameter int l = 16,
  parameter int p = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [p:0]   Operation,
  input  logic [l-1:0] A,
  input  logic [l-1:0] B,
  input  logic [l-1:0] FlagsIn,
  output logic         Busy,
  output logic         Done,
  output logic [l-1:0] R,
  output logic [l-1:0] FlagsOut
);

  localparam int CW = $clog2(l);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [p:0] OP_DIV = (p+1)'(0);
  localparam logic [p:0] OP_MUL = (p+1)'(1);
  localparam logic [p:0] OP_REM = (p+1)'(2);

  localparam logic [l-1:0] MIN_NEG = {1'b1, {(l-1){1'b0}}};

  logic [1:0]     state;
  logic [p:0]     op_q;
  logic [l-1:0]   flags_q;
  logic [l-1:0]   mag_a;
  logic [l-1:0]   mag_b;
  logic           sign_r;
  logic           sign_a;
  logic [CW-1:0]  cnt;
  logic [2*l-1:0] acc;

  // ---------------- acceptance-side decode (operates on live inputs) ----------------
  logic [l-1:0] abs_a, abs_b;
  logic         in_div, in_mul, in_rem, in_unsup, in_short;
  logic [l-1:0] short_flags;

  always_comb begin
    abs_a    = A[l-1] ? -A : A;
    abs_b    = B[l-1] ? -B : B;
    in_div   = (Operation == OP_DIV);
    in_mul   = (Operation == OP_MUL);
    in_rem   = (Operation == OP_REM);
    in_unsup = !(in_div || in_mul || in_rem);
    in_short = in_unsup || ((in_div || in_rem) && (B == '0));
    short_flags = FlagsIn;
    if ((in_div || in_rem) && (B == '0))
      short_flags[1:0] = 2'b10;
`ifdef SEQ_MULDIV_EARLY_OUT_EN
    // A zero multiplier needs no iterations at all.
    if (in_mul && (B == '0)) begin
      in_short       = 1'b1;
      short_flags[2] = 1'b0;
    end
`endif
  end

  // ---------------- shared iteration datapath ----------------
  // acc = {hi, lo}. Multiply: hi accumulates, lo holds the multiplier and shifts right,
  // receiving product bits from the top. Divide: hi is the partial remainder, lo the
  // dividend shifting left while quotient bits enter at the bottom.
  logic [l-1:0]   hi, lo;
  logic [l:0]     add_sum;
  logic [l:0]     shifted;
  logic [l+1:0]   trial;
  logic           div_ok;
  logic [2*l-1:0] acc_step;
  logic [2*l-1:0] fin_acc;
  logic           is_mul;
  logic           last_step;

  always_comb begin
    hi      = acc[2*l-1:l];
    lo      = acc[l-1:0];
    is_mul  = (op_q == OP_MUL);
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : {(l+1){1'b0}});
    shifted = {hi, lo[l-1]};
    trial   = {1'b0, shifted} - {2'b00, mag_b};
    div_ok  = !trial[l+1];
    if (is_mul)
      acc_step = {add_sum, lo[l-1:1]};
    else
      acc_step = {(div_ok ? trial[l-1:0] : shifted[l-1:0]), lo[l-2:0], div_ok};
    last_step = (cnt == '0);
    fin_acc   = acc_step;
  end

`ifdef SEQ_MULDIV_EARLY_OUT_EN
  // Unconsumed multiplier bits sit in lo[cnt:0] before this step; after it they are
  // lo[cnt:1]. Once those are zero the remaining iterations would only shift, so the
  // final product is acc_step shifted right by the iterations we skip.
  logic [l-1:0] one_l;
  logic [l-1:0] rest_mask;
  logic         mul_rest_zero;
  logic [2*l-1:0] early_acc;

  always_comb begin
    one_l         = {{(l-1){1'b0}}, 1'b1};
    rest_mask     = (one_l << cnt) - one_l;
    mul_rest_zero = (((lo >> 1) & rest_mask) == '0);
    early_acc     = acc_step >> cnt;
  end
`endif

  logic calc_exit;
  logic [2*l-1:0] res_acc;

  always_comb begin
    calc_exit = last_step;
    res_acc   = fin_acc;
`ifdef SEQ_MULDIV_EARLY_OUT_EN
    if (is_mul && mul_rest_zero) begin
      calc_exit = 1'b1;
      res_acc   = early_acc;
    end
`endif
  end

  // ---------------- result shaping (sign, flags) ----------------
  logic [l-1:0] mag_lo, quo, rmd;
  logic         mul_ovf, div_ovf, has_rem;
  logic [l-1:0] calc_r, calc_flags;

  always_comb begin
    mag_lo  = res_acc[l-1:0];
    quo     = res_acc[l-1:0];
    rmd     = res_acc[2*l-1:l];
    has_rem = (rmd != '0);
    // Magnitude >= 2^(l-1) overflows, except exactly 2^(l-1) for a negative product.
    mul_ovf = (res_acc[2*l-1:l] != '0) ||
              (mag_lo[l-1] && !(sign_r && (mag_lo[l-2:0] == '0)));
    // Only -2^(l-1) / -1 yields a positive quotient of 2^(l-1).
    div_ovf = (quo == MIN_NEG) && !sign_r;
    calc_r     = '0;
    calc_flags = flags_q;
    if (is_mul) begin
      calc_r        = sign_r ? -mag_lo : mag_lo;
      calc_flags[2] = mul_ovf;
    end else if (op_q == OP_DIV) begin
      calc_r          = sign_r ? -quo : quo;
      calc_flags[1:0] = {1'b0, has_rem};
      if (div_ovf)
        calc_flags[2] = 1'b1;
    end else begin
      calc_r          = sign_a ? -rmd : rmd;
      calc_flags[1:0] = {1'b0, has_rem};
    end
  end

  // ---------------- control and state ----------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      flags_q  <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      sign_r   <= 1'b0;
      sign_a   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      R        <= '0;
      FlagsOut <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            op_q    <= Operation;
            flags_q <= FlagsIn;
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            sign_r  <= A[l-1] ^ B[l-1];
            sign_a  <= A[l-1];
            cnt     <= CW'(l-1);
            acc     <= {{l{1'b0}}, (in_mul ? abs_b : abs_a)};
            if (in_short) begin
              R        <= '0;
              FlagsOut <= short_flags;
              Done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              Busy  <= 1'b1;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
          if (calc_exit) begin
            Busy     <= 1'b0;
            Done     <= 1'b1;
            R        <= calc_r;
            FlagsOut <= calc_flags;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          Done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv_alu.sv
module tb_seq_muldiv_alu;

  localparam int L = 16;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic [1:0]    Operation;
  logic [L-1:0]  A, B, FlagsIn;
  logic          Busy, Done;
  logic [L-1:0]  R, FlagsOut;

  seq_muldiv_alu #(.l(L), .p(1)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Operation(Operation),
    .A(A), .B(B), .FlagsIn(FlagsIn),
    .Busy(Busy), .Done(Done), .R(R), .FlagsOut(FlagsOut)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_acc = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: plain integer arithmetic ----------------
  typedef struct packed {
    logic [L-1:0] r;
    logic [L-1:0] f;
  } res_t;

  function automatic res_t model(input logic [1:0] op, input logic [L-1:0] a, b, fin);
    longint sa, sb, q, rm, pr;
    res_t o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o.r = '0;
    o.f = fin;
    if (op == 2'd1) begin
      pr = sa * sb;
      o.r = pr[L-1:0];
      o.f[2] = (pr > 32767) || (pr < -32768);
    end else if (op == 2'd0 || op == 2'd2) begin
      if (sb == 0) begin
        o.f[1] = 1'b1;
        o.f[0] = 1'b0;
      end else begin
        q  = sa / sb;
        rm = sa % sb;
        o.f[1] = 1'b0;
        o.f[0] = (rm != 0);
        if (op == 2'd0) begin
          o.r = q[L-1:0];
          if (q > 32767) o.f[2] = 1'b1;
        end else begin
          o.r = rm[L-1:0];
        end
      end
    end
    return o;
  endfunction

  function automatic int lat_of(input logic [1:0] op, input logic [L-1:0] b);
    int sb;
    int msb;
    sb = int'($signed(b));
    if (sb < 0) sb = -sb;
    if (op == 2'd3) return 1;
    if (op != 2'd1 && sb == 0) return 1;
`ifdef SEQ_MULDIV_EARLY_OUT_EN
    if (op == 2'd1) begin
      if (sb == 0) return 1;
      msb = 0;
      for (int i = 0; i < 32; i++) if (sb >= (1 << i)) msb = i;
      return msb + 2;
    end
`else
    msb = 0;
`endif
    return L + 1;
  endfunction

  // Model of the observable protocol: Busy window, Done pulse, held result.
  logic          m_busy = 1'b0, m_done = 1'b0;
  int            m_left = 0;
  res_t          m_res = '0;
  logic [L-1:0]  m_r = '0, m_f = '0;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_r <= '0; m_f <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_r <= m_res.r; m_f <= m_res.f;
      end
      m_left <= m_left - 1;
    end else if (Start) begin
      m_res <= model(Operation, A, B, FlagsIn);
      if (lat_of(Operation, B) == 1) begin
        m_done <= 1'b1;
        m_r <= model(Operation, A, B, FlagsIn).r;
        m_f <= model(Operation, A, B, FlagsIn).f;
      end else begin
        m_busy <= 1'b1;
        m_left <= lat_of(Operation, B) - 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge Clock) begin
    chk("busy", Busy, m_busy);
    chk("done", Done, m_done);
    chk("r", R, m_r);
    chk("flags", FlagsOut, m_f);
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic issue(input logic [1:0] op, input logic [L-1:0] a, b, fin);
    @(negedge Clock);
    Start = 1'b1; Operation = op; A = a; B = b; FlagsIn = fin;
    @(negedge Clock);
    t_acc = cyc;
    Start = 1'b0;
    // Operands are free to change once accepted.
    A = 16'($urandom); B = 16'($urandom); FlagsIn = 16'($urandom);
    Operation = 2'($urandom);
  endtask

  task automatic wait_done(input string name, input logic [L-1:0] er, ef, input int elat);
    while (!Done && (cyc - t_acc) < 40) @(negedge Clock);
    chk({name, "_done_seen"}, Done, 1'b1);
    chk({name, "_latency"}, cyc - t_acc + 1, elat);
    chk({name, "_r"}, R, er);
    chk({name, "_flags"}, FlagsOut, ef);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [L-1:0] a, b, fin,
                        input logic [L-1:0] er, ef, input int lat_n, input int lat_e);
    issue(op, a, b, fin);
`ifdef SEQ_MULDIV_EARLY_OUT_EN
    wait_done(name, er, ef, lat_e);
`else
    wait_done(name, er, ef, lat_n);
`endif
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Operation = '0; A = '0; B = '0; FlagsIn = '0;
    repeat (3) @(negedge Clock);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_done", Done, 1'b0);
    chk("reset_r", R, 16'h0000);
    chk("reset_flags", FlagsOut, 16'h0000);
    #2 Reset = 1'b0;

    run_op("mul_7_m6",      2'd1, 16'd7,     -16'sd6,   16'h0000, 16'hFFD6, 16'h0000, 17, 4);
    run_op("mul_ovf",       2'd1, 16'd300,   16'd200,   16'h0003, 16'hEA60, 16'h0007, 17, 9);
    run_op("mul_min_x1",    2'd1, 16'h8000,  16'd1,     16'h0004, 16'h8000, 16'h0000, 17, 2);
    run_op("mul_m1_m1",     2'd1, 16'hFFFF,  16'hFFFF,  16'h0000, 16'h0001, 16'h0000, 17, 2);
    run_op("mul_m128_256",  2'd1, -16'sd128, 16'd256,   16'h0000, 16'h8000, 16'h0000, 17, 10);
    run_op("mul_1234_3",    2'd1, 16'd1234,  16'd3,     16'h0000, 16'h0E76, 16'h0000, 17, 3);
    run_op("mul_by_zero",   2'd1, 16'd1234,  16'd0,     16'h0000, 16'h0000, 16'h0000, 17, 1);
    run_op("div_m7_2",      2'd0, -16'sd7,   16'd2,     16'h0000, 16'hFFFD, 16'h0001, 17, 17);
    run_op("rem_m7_2",      2'd2, -16'sd7,   16'd2,     16'h0004, 16'hFFFF, 16'h0005, 17, 17);
    run_op("div_min_m1",    2'd0, 16'h8000,  16'hFFFF,  16'h0000, 16'h8000, 16'h0004, 17, 17);
    run_op("rem_100_m7",    2'd2, 16'd100,   -16'sd7,   16'h0002, 16'h0002, 16'h0001, 17, 17);
    run_op("div_m100_10",   2'd0, -16'sd100, 16'd10,    16'h0001, 16'hFFF6, 16'h0000, 17, 17);
    run_op("div_by_zero",   2'd0, 16'd5,     16'd0,     16'hFFF8, 16'h0000, 16'hFFFA, 1, 1);
    run_op("rem_by_zero",   2'd2, 16'd5,     16'd0,     16'h0004, 16'h0000, 16'h0006, 1, 1);
    run_op("unsupported",   2'd3, 16'd9,     16'd4,     16'h1235, 16'h0000, 16'h1235, 1, 1);

    // Start pulsed mid-operation with other operands is dropped.
    issue(2'd0, 16'd1000, 16'd7, 16'h0000);
    repeat (4) @(negedge Clock);
    Start = 1'b1; Operation = 2'd1; A = 16'd3; B = 16'd3; FlagsIn = 16'h0004;
    @(negedge Clock);
    Start = 1'b0;
    wait_done("busy_start", 16'h008E, 16'h0001, 17);

    // Start held through the Done cycle is not a second request.
    @(negedge Clock);
    Start = 1'b1; Operation = 2'd3; A = 16'd1; B = 16'd1; FlagsIn = 16'h00AA;
    @(negedge Clock);
    FlagsIn = 16'h0055;
    chk("start_in_done_pulse", Done, 1'b1);
    chk("start_in_done_flags", FlagsOut, 16'h00AA);
    @(negedge Clock);
    Start = 1'b0;
    chk("start_in_done_nopulse", Done, 1'b0);
    chk("start_in_done_held", FlagsOut, 16'h00AA);

    // Reset in the middle of a divide.
    issue(2'd0, 16'd1000, 16'd3, 16'h0000);
    repeat (7) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_busy", Busy, 1'b0);
    chk("midrst_done", Done, 1'b0);
    chk("midrst_r", R, 16'h0000);
    chk("midrst_flags", FlagsOut, 16'h0000);
    @(negedge Clock);
    #2 Reset = 1'b0;
    run_op("after_reset",   2'd0, 16'd1000,  16'd3,     16'h0000, 16'd333,  16'h0001, 17, 17);

    repeat (3) @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_muldiv_alu.md
Name: seq_muldiv_alu

Overview:
- Multi-cycle, parametrised successor to the combinational signed mul/div ALU.
- Computes signed multiply, divide and remainder on l-bit two's-complement operands using one shared l-iteration shift/add-subtract datapath, one bit per clock.
- Uses a Start/Busy/Done handshake and registered, held results.
- Sits between the register file and writeback; owns the shared arithmetic flags.

Parameters:
- l, 16, operand/result width in bits (l >= 4).
- p, 1, Operation select MSB index (Operation is p+1 bits; p >= 1).

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- Operation  input  p+1  0 = divide, 1 = multiply, 2 = remainder, others = unsupported.
- A  input  l  signed dividend / multiplicand.
- B  input  l  signed divisor / multiplier.
- FlagsIn  input  l  incoming flag word.
- Busy  output  1  high from the cycle after Start is accepted until Done.
- Done  output  1  one-cycle pulse; R/FlagsOut are valid from this cycle.
- R  output  l  signed result, held until the next accepted Start.
- FlagsOut  output  l  outgoing flag word, held like R.

Behaviour:
- Flag bit indices: DivisionHasRemainderIdx = 0, DivisionByZeroIdx = 1, MultiplicationOverflowIdx = 2, NoFlagsIdx = 3.
- FlagsOut[l-1:3] always equals the latched FlagsIn[l-1:3].
- Reset (any time, including mid-operation): state = IDLE; Busy, Done, R and FlagsOut all 0. The in-flight operation is discarded.
- IDLE + Start:
  - Latch Operation and FlagsIn.
  - Latch |A| and |B| as l-bit unsigned magnitudes (|-2^(l-1)| = 2^(l-1)).
  - Latch SignR = A[l-1]^B[l-1] and SignA = A[l-1].
  - Load iteration counter = l-1.
- Short path (div/rem with B = 0, or unsupported op): next state DONE. Done is high exactly 1 cycle after acceptance.
  - Div/rem, B = 0: R = 0; DivisionByZero = 1; HasRemainder = 0; Overflow passes through from FlagsIn.
  - Unsupported op: R = 0; flag bits [2:0] pass through.
- CALC runs for exactly l cycles. The counter decrements each cycle; leave CALC when counter = 0 is processed.
  - Multiply: shift-add on a 2l-bit accumulator using the multiplier magnitude LSB-first.
  - Div/rem: restoring division, MSB-first. Quotient and remainder are magnitudes.
- DONE (1 cycle): apply sign, register R and FlagsOut, pulse Done, return to IDLE.
  - Latency: Start edge k -> Done high in cycle k+l+1.
- Multiply result:
  - R = low l bits of the signed product.
  - MultiplicationOverflow = 1 iff the magnitude exceeds 2^(l-1)-1, except magnitude = 2^(l-1) with SignR = 1, which is not overflow.
  - Division flags pass through.
- Divide result:
  - R = quotient, negated if SignR.
  - HasRemainder = (remainder magnitude != 0). DivisionByZero = 0.
  - Quotient magnitude 2^(l-1) with SignR = 0 (i.e. -2^(l-1) / -1): R = 2^(l-1) bit pattern and MultiplicationOverflow = 1. Otherwise the overflow flag passes through.
- Remainder result:
  - R = remainder magnitude, negated if SignA (truncating division semantics).
  - Division flags set as for divide; overflow passes through.
- Start while Busy or in DONE: ignored, with no queuing.
- Start in the same cycle as the Done pulse: ignored. Start is accepted only in IDLE.
- Operands A/B/FlagsIn may change freely after acceptance without affecting the result.

Optional Feature:
- Macro: SEQ_MULDIV_EARLY_OUT_EN.
- Defined: multiply leaves CALC as soon as the remaining unshifted multiplier bits are all zero; the result is identical.
  - Latency = (index of the multiplier magnitude's highest set bit) + 2 cycles.
  - Multiplier magnitude 0 -> Done after 1 cycle, R = 0.
  - Division latency is unchanged.
- Undefined: fixed l+1 latency for all non-short-path operations.

Test Plan:
- l=16, Op=1, A=7, B=-6 -> R=0xFFD6 (-42), Overflow=0, Done at cycle 17, Busy high in cycles 1-16.
- Op=1, A=300, B=200 -> Overflow=1. Then Op=1, A=-32768, B=1 -> R=0x8000, Overflow=0.
- Op=0, A=-7, B=2 -> R=0xFFFD, HasRemainder=1. Op=2, same operands -> R=0xFFFF. Op=0, A=-32768, B=-1 -> R=0x8000, Overflow=1.
- Op=0, A=5, B=0, FlagsIn=0xFFF8 -> Done at cycle 1, R=0, FlagsOut=0xFFFA. Op=3 -> Done at cycle 1, FlagsOut=FlagsIn, R=0.
- Start pulsed during Busy with different operands -> ignored, original result returned. Reset asserted at cycle 8 of a divide -> Busy/Done/R/FlagsOut = 0 immediately, IDLE, next Start works normally.
- With SEQ_MULDIV_EARLY_OUT_EN, Op=1, A=1234, B=3 -> R=3702, Done at cycle 3. B=0 -> Done at cycle 1, R=0.
